fixed_shrink_stream: RTL and testbench

Streaming fixed-point shrink activation for the activation-layer library. It applies soft-shrink or hard-shrink to each element with a threshold (lambda) and mode that are programmable at run time. New settings are committed only on frame boundaries. The datapath is a 2-stage valid/ready pipeline with round-to-nearest, saturating output casting and a per-frame zero-count (sparsity) report. It sits between tensor-producing layers and downstream consumers in the same dataflow as the other activation blocks.

---
 rtl/fixed_shrink_stream.sv | 172 +++++++++++++++++
 tb/tb_fixed_shrink_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_shrink_stream.sv
// Streaming soft/hard shrink activation: frame-aligned config commit, 2-stage
// valid/ready pipeline, round/saturate output cast and per-frame zero count.
module fixed_shrink_stream #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int LAMBDA_WIDTH                = 8,
  parameter int LAMBDA_DEFAULT              = 8,
  parameter int MODE_DEFAULT                = 0,
  localparam int PAR   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
  localparam int BEATS = (DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1 + PAR - 1) / PAR,
  localparam int ZC_W  = $clog2(BEATS * PAR + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PAR*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                  data_in_0_valid,
  output logic                                  data_in_0_ready,
  output logic [PAR*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                  data_out_0_valid,
  input  logic                                  data_out_0_ready,
  input  logic [LAMBDA_WIDTH-1:0]               cfg_lambda,
  input  logic                                  cfg_mode,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  output logic [ZC_W-1:0]                       zero_count,
  output logic                                  zero_count_valid
);

  localparam int IW   = DATA_IN_0_PRECISION_0;
  localparam int IFR  = DATA_IN_0_PRECISION_1;
  localparam int OW   = DATA_OUT_0_PRECISION_0;
  localparam int OFR  = DATA_OUT_0_PRECISION_1;
  localparam int LW   = LAMBDA_WIDTH;
  localparam int EW   = ((IW > LW) ? IW : LW) + 2;
  localparam int SHR  = (OFR < IFR) ? IFR - OFR : 0;
  localparam int SHL  = (OFR < IFR) ? 0 : OFR - IFR;
  localparam int CW0  = EW + SHL + 1;
  localparam int CW   = (CW0 > OW + 1) ? CW0 : OW + 1;
  localparam int BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic signed [CW-1:0] RND  = (SHR > 0) ? (CW'(1) << ((SHR > 0) ? SHR - 1 : 0)) : '0;
  localparam logic signed [CW-1:0] MAXV = CW'((1 << (OW - 1)) - 1);
  localparam logic signed [CW-1:0] MINV = CW'(-(1 << (OW - 1)));

  logic [LW-1:0]   active_lambda, pending_lambda, eff_lambda;
  logic            active_mode, pending_mode, eff_mode, pending_valid;
  logic [BC_W-1:0] beat_cnt;
  logic [ZC_W-1:0] acc, beat_zeros;
  logic            first_beat, last_beat, in_fire, cfg_fire, s1_adv, s2_load;
  logic            s1_valid, s2_valid;

  logic signed [EW-1:0] lam_ext;
  logic signed [EW-1:0] x_ext   [PAR];
  logic signed [EW-1:0] shrunk  [PAR];
  logic signed [EW-1:0] s1_data [PAR];
  logic signed [CW-1:0] wide    [PAR];
  logic [PAR-1:0]       zero_flag;
  logic [PAR*OW-1:0]    cast_flat;

  assign s2_load          = !s2_valid || data_out_0_ready;
  assign s1_adv           = s2_load || !s1_valid;
  assign data_in_0_ready  = s1_adv;
  assign in_fire          = data_in_0_valid && s1_adv;
  assign cfg_ready        = !pending_valid;
  assign cfg_fire         = cfg_valid && cfg_ready;
  assign first_beat       = (beat_cnt == '0);
  assign last_beat        = (beat_cnt == BC_W'(BEATS - 1));
  assign data_out_0_valid = s2_valid;

  // A pending config takes effect on beat 0 itself, so a whole frame sees one setting.
  always_comb begin
    eff_lambda = active_lambda;
    eff_mode   = active_mode;
    if (first_beat && pending_valid) begin
      eff_lambda = pending_lambda;
      eff_mode   = pending_mode;
    end
    lam_ext    = $signed({{(EW - LW){1'b0}}, eff_lambda});
    beat_zeros = '0;
    zero_flag  = '0;
    for (int i = 0; i < PAR; i++) begin
      x_ext[i]     = EW'($signed(data_in_0[i*IW +: IW]));
      shrunk[i]    = '0;
      zero_flag[i] = 1'b1;
      if (x_ext[i] > lam_ext) begin
        zero_flag[i] = 1'b0;
        shrunk[i]    = eff_mode ? x_ext[i] : x_ext[i] - lam_ext;
      end else if (x_ext[i] < -lam_ext) begin
        zero_flag[i] = 1'b0;
        shrunk[i]    = eff_mode ? x_ext[i] : x_ext[i] + lam_ext;
      end
      beat_zeros = beat_zeros + ZC_W'(zero_flag[i]);
    end
  end

  // Round half up (only when dropping fraction bits), then clamp to the output range.
  always_comb begin
    cast_flat = '0;
    for (int i = 0; i < PAR; i++) begin
      wide[i] = CW'(s1_data[i]);
      wide[i] = (wide[i] + RND) >>> SHR;
      wide[i] = wide[i] <<< SHL;
      if (wide[i] > MAXV) begin
        cast_flat[i*OW +: OW] = MAXV[OW-1:0];
      end else if (wide[i] < MINV) begin
        cast_flat[i*OW +: OW] = MINV[OW-1:0];
      end else begin
        cast_flat[i*OW +: OW] = wide[i][OW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      data_out_0 <= '0;
      for (int i = 0; i < PAR; i++) s1_data[i] <= '0;
    end else begin
      if (s1_adv) s1_valid <= data_in_0_valid;
      if (in_fire) begin
        for (int i = 0; i < PAR; i++) s1_data[i] <= shrunk[i];
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) data_out_0 <= cast_flat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_lambda    <= LW'(LAMBDA_DEFAULT);
      active_mode      <= 1'(MODE_DEFAULT);
      pending_lambda   <= '0;
      pending_mode     <= 1'b0;
      pending_valid    <= 1'b0;
      beat_cnt         <= '0;
      acc              <= '0;
      zero_count       <= '0;
      zero_count_valid <= 1'b0;
    end else begin
      if (cfg_fire) begin
        pending_lambda <= cfg_lambda;
        pending_mode   <= cfg_mode;
        pending_valid  <= 1'b1;
      end
      if (in_fire) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (first_beat && pending_valid) begin
          active_lambda <= pending_lambda;
          active_mode   <= pending_mode;
          pending_valid <= 1'b0;
        end
        if (last_beat) begin
          zero_count <= acc + beat_zeros;
          acc        <= '0;
        end else begin
          acc <= acc + beat_zeros;
        end
      end
      zero_count_valid <= in_fire && last_beat;
    end
  end

endmodule

// File: tb/tb_fixed_shrink_stream.sv
// Directed-vector bench for fixed_shrink_stream: value table, config commit,
// 4/2 rounding/saturation, backpressure, zero count and mid-frame reset.
module tb_fixed_shrink_stream;

  typedef struct { logic [7:0] din; logic [7:0] exp; } vec_t;
  typedef struct { logic [7:0] din; logic [3:0] exp; } vec42_t;

  vec_t   vec   [46];
  vec42_t vec42 [3];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [3:0] got42 [$];
  int checks = 0;
  int errors = 0;
  int fire_count = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din, dout, cfg_lambda;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       cfg_mode, cfg_valid, cfg_ready, zcv;
  logic [3:0] zero_count;
  logic [7:0] d42_din;
  logic       d42_valid, d42_in_ready, d42_out_valid, d42_cfg_ready, d42_zcv;
  logic [3:0] d42_out, d42_zc;

  always #5 clk = ~clk;

  fixed_shrink_stream u_dut (
    .clk(clk), .rst(rst),
    .data_in_0(din), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready),
    .data_out_0(dout), .data_out_0_valid(out_valid), .data_out_0_ready(out_ready),
    .cfg_lambda(cfg_lambda), .cfg_mode(cfg_mode), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .zero_count(zero_count), .zero_count_valid(zcv)
  );

  fixed_shrink_stream #(.DATA_OUT_0_PRECISION_0(4), .DATA_OUT_0_PRECISION_1(2)) u_dut42 (
    .clk(clk), .rst(rst),
    .data_in_0(d42_din), .data_in_0_valid(d42_valid), .data_in_0_ready(d42_in_ready),
    .data_out_0(d42_out), .data_out_0_valid(d42_out_valid), .data_out_0_ready(1'b1),
    .cfg_lambda(8'h00), .cfg_mode(1'b0), .cfg_valid(1'b0), .cfg_ready(d42_cfg_ready),
    .zero_count(d42_zc), .zero_count_valid(d42_zcv)
  );

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(dout);
    if (in_valid && in_ready) fire_count++;
    if (d42_out_valid) got42.push_back(d42_out);
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_beat(input logic [7:0] x);
    int n = 0;
    din = x;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_output("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int idx);
    exp_q.push_back(vec[idx].exp);
    send_beat(vec[idx].din);
  endtask

  task automatic apply_cfg(input logic [7:0] lam, input logic mode);
    int n = 0;
    cfg_lambda = lam;
    cfg_mode = mode;
    cfg_valid = 1'b1;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) check_output("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drain_compare(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_output({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_output(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // frame 1: soft, lambda 0.5 (4 elements with |x| <= 8)
    vec[0] = '{8'h20, 8'h18}; vec[1] = '{8'hE0, 8'hE8}; vec[2] = '{8'h08, 8'h00};
    vec[3] = '{8'hF8, 8'h00}; vec[4] = '{8'h09, 8'h01}; vec[5] = '{8'hF7, 8'hFF};
    vec[6] = '{8'h00, 8'h00}; vec[7] = '{8'h05, 8'h00}; vec[8] = '{8'h7F, 8'h77};
    vec[9] = '{8'h80, 8'h88};
    // frame 2: still soft after a mid-frame cfg write
    vec[10] = '{8'h30, 8'h28}; vec[11] = '{8'hD0, 8'hD8}; vec[12] = '{8'h01, 8'h00};
    for (int i = 13; i < 20; i++) vec[i] = '{8'h11, 8'h09};
    // frame 3: hard, lambda 1.0
    vec[20] = '{8'h11, 8'h11}; vec[21] = '{8'h10, 8'h00}; vec[22] = '{8'hEF, 8'hEF};
    vec[23] = '{8'h20, 8'h20}; vec[24] = '{8'hF0, 8'h00};
    for (int i = 25; i < 30; i++) vec[i] = '{8'h00, 8'h00};
    // backpressure stream, hard lambda 1.0
    vec[30] = '{8'h40, 8'h40}; vec[31] = '{8'hC0, 8'hC0}; vec[32] = '{8'h21, 8'h21};
    vec[33] = '{8'h05, 8'h00}; vec[34] = '{8'h7F, 8'h7F}; vec[35] = '{8'h80, 8'h80};
    // after reset: defaults again
    vec[36] = '{8'h11, 8'h09}; vec[37] = '{8'h08, 8'h00};
    for (int i = 38; i < 46; i++) vec[i] = '{8'h18, 8'h10};
    vec42[0] = '{8'h7F, 4'h7}; vec42[1] = '{8'h13, 4'h3}; vec42[2] = '{8'h81, 4'h8};

    rst = 1'b0; din = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_lambda = '0; cfg_mode = 1'b0; cfg_valid = 1'b0;
    d42_din = '0; d42_valid = 1'b0;
    #2;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_dout", 32'(dout), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_output("rst_zero_count", 32'(zero_count), 32'd0);
    check_output("rst_zc_valid", 32'(zcv), 32'd0);
    check_output("rst42_in_ready", 32'(d42_in_ready), 32'd1);
    check_output("rst42_cfg_ready", 32'(d42_cfg_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      d42_din = vec42[i].din;
      d42_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    d42_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("cast42_count", 32'(got42.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got42.size()) check_output("cast42", 32'(got42[i]), 32'(vec42[i].exp));
    check_output("cast42_zc", {27'd0, d42_zcv, d42_zc}, 32'd0);

    exp_q.push_back(vec[0].exp);
    din = vec[0].din;
    in_valid = 1'b1;
    @(negedge clk);
    check_output("lat_in_ready", 32'(in_ready), 32'd1);
    check_output("lat_cycle0", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output("lat_cycle2", 32'(out_valid), 32'd1);
    check_output("lat_data", 32'(dout), 32'h18);
    @(posedge clk);
    #1;

    for (int i = 1; i < 30; i++) begin
      apply_stimulus(i);
      if (i == 9) begin
        check_output("zc_frame1", 32'(zero_count), 32'd4);
        check_output("zc_pulse", 32'(zcv), 32'd1);
        @(posedge clk);
        #1;
        check_output("zc_pulse_width", 32'(zcv), 32'd0);
      end
      if (i == 12) begin
        check_output("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        apply_cfg(8'h10, 1'b1);
        check_output("cfg_ready_pending", 32'(cfg_ready), 32'd0);
      end
      if (i == 19) begin
        check_output("zc_frame2", 32'(zero_count), 32'd1);
        check_output("cfg_ready_held", 32'(cfg_ready), 32'd0);
      end
      if (i == 20) check_output("cfg_ready_commit", 32'(cfg_ready), 32'd1);
      if (i == 29) begin
        check_output("zc_frame3", 32'(zero_count), 32'd7);
        check_output("zc_pulse3", 32'(zcv), 32'd1);
      end
    end
    drain_compare("frames");

    out_ready = 1'b0;
    begin
      int base;
      base = fire_count;
      fork
        for (int i = 30; i < 36; i++) apply_stimulus(i);
        begin
          repeat (5) @(negedge clk);
          check_output("bp_accepted", 32'(fire_count - base), 32'd2);
          check_output("bp_in_ready", 32'(in_ready), 32'd0);
          check_output("bp_out_valid", 32'(out_valid), 32'd1);
          check_output("bp_hold", 32'(dout), 32'h40);
          @(posedge clk);
          #1;
          out_ready = 1'b1;
        end
      join
    end
    drain_compare("backpressure");

    apply_cfg(8'h20, 1'b0);
    check_output("cfg_pending_mid", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 3; i++) send_beat(8'h40);
    rst = 1'b0;
    #1;
    check_output("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_output("mid_rst_dout", 32'(dout), 32'd0);
    check_output("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_output("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_output("mid_rst_zero_count", 32'(zero_count), 32'd0);
    check_output("mid_rst_zc_valid", 32'(zcv), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int i = 36; i < 46; i++) apply_stimulus(i);
    check_output("zc_after_reset", 32'(zero_count), 32'd1);
    check_output("zc_pulse_after_reset", 32'(zcv), 32'd1);
    drain_compare("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
